// File: rtl/uart_tx_parity.sv
// uart_tx_parity: UART transmitter, start + LSB-first data + optional even-ones parity + stop.
module uart_tx_parity #(
    parameter int TxNbit   = 8,
    parameter int BAUD_DIV = 5208
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TxNbit-1:0] Txbuff,
    input  logic              transmit,
    input  logic              parity_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(TxNbit + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [IW-1:0]     idx, idx_d;
    logic [TxNbit-1:0] sh, sh_d;
    logic              par, par_d, pen, pen_d, last, tx_d, busy_d, done_d;
    assign last = cnt == CW'(BAUD_DIV - 1);
    always_comb begin
        state_d = state;
        cnt_d   = last ? '0 : cnt + 1'b1;
        idx_d   = idx;
        sh_d    = sh;
        par_d   = par;
        pen_d   = pen;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (transmit) begin
                    state_d = START;
                    sh_d    = Txbuff;
                    par_d   = ~^Txbuff;
                    pen_d   = parity_en;
                    idx_d   = '0;
                end
            end
            START:  if (last) state_d = DATA;
            DATA: if (last) begin
                sh_d  = sh >> 1;
                idx_d = idx + 1'b1;
                if (idx == IW'(TxNbit - 1)) state_d = pen ? PARITY : STOP;
            end
            PARITY: if (last) state_d = STOP;
            STOP:   if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are computed from next state so they leave a flop each cycle
        tx_d   = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
        busy_d = state_d != IDLE;
        done_d = state_d == STOP && cnt_d == CW'(BAUD_DIV - 1);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            par     <= 1'b0;
            pen     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            sh      <= sh_d;
            par     <= par_d;
            pen     <= pen_d;
            tx      <= tx_d;
            busy    <= busy_d;
            tx_done <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_parity.sv
// tb_uart_tx_parity: scoreboard bench; a frame model queues expected frames, a monitor checks the line.
module tb_uart_tx_parity;
    localparam int B = 4;
    typedef struct {
        int         start;
        logic [7:0] d;
        bit         pe;
    } frame_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] Txbuff = 8'h00;
    logic       transmit = 1'b0;
    logic       parity_en = 1'b0;
    logic       tx, busy, tx_done;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         next_free = 0;
    frame_t     q[$];
    frame_t     cur;
    bit         in_frame = 0;
    int         pos = 0;
    int         flen = 0;

    uart_tx_parity #(.TxNbit(8), .BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .Txbuff(Txbuff), .transmit(transmit),
        .parity_en(parity_en), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_bit(input frame_t f, input int b);
        if (b == 0) return 0;
        if (b <= 8) return int'(f.d[b-1]);
        if (b == 9 && f.pe) return ($countones(f.d) % 2 == 0) ? 1 : 0;
        return 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // model: a request is taken only once the previous frame plus one idle cycle is over
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            next_free <= 0;
        end else if (transmit && cyc >= next_free) begin
            q.push_back('{start: cyc + 1, d: Txbuff, pe: parity_en});
            next_free <= cyc + (10 + int'(parity_en)) * B + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 0;
        end else begin
            if (!in_frame && q.size() > 0 && cyc > q[0].start) begin
                chk("missed_frame_start", cyc, q[0].start);
                void'(q.pop_front());
            end
            if (!in_frame && busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("frame_start_cycle", cyc, cur.start);
                    in_frame = 1;
                    pos = 0;
                    flen = (10 + int'(cur.pe)) * B;
                end
            end
            if (in_frame) begin
                chk("tx_bit", int'(tx), exp_bit(cur, pos / B));
                chk("busy_in_frame", int'(busy), 1);
                chk("tx_done", int'(tx_done), (pos == flen - 1) ? 1 : 0);
                pos++;
                if (pos == flen) in_frame = 0;
            end else begin
                chk("idle_tx", int'(tx), 1);
                chk("idle_busy", int'(busy), 0);
                chk("idle_tx_done", int'(tx_done), 0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit pe, input int hold);
        @(negedge clk);
        Txbuff = d;
        parity_en = pe;
        transmit = 1'b1;
        repeat (hold) @(negedge clk);
        transmit = 1'b0;
    endtask

    initial begin
        int w;
        #2 reset = 1'b0;
        #1 chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tx_done", int'(tx_done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h55, 1, 1);
        repeat (50) @(negedge clk);
        send(8'h07, 1, 1);
        repeat (50) @(negedge clk);
        send(8'h07, 0, 1);
        repeat (45) @(negedge clk);
        send(8'h12, 1, 1);
        repeat (10) @(negedge clk);
        Txbuff = 8'hFF;
        parity_en = 1'b0;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        repeat (40) @(negedge clk);
        send(8'hA3, 1, 60);
        repeat (50) @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            Txbuff = 8'($urandom);
            parity_en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (50) @(negedge clk);
        send(8'h00, 1, 1);
        repeat (17) @(negedge clk);
        #1 chk("pre_reset_tx_bit3", int'(tx), 0);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b0;
        #1 chk("async_reset_tx", int'(tx), 1);
        chk("async_reset_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h3C, 1, 1);
        w = 0;
        while ((q.size() != 0 || in_frame) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", (w < 200) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_parity.md
Name: uart_tx_parity

Overview:
- UART serial transmitter with an optional parity bit.
- Frame format: 1 start bit (0), TxNbit data bits LSB first, an optional parity bit, 1 stop bit (1).
- Parity bit = XNOR-reduction of the data word (1 when the data has an even count of ones). This is the same rule the receive-side parity checker uses, so a looped-back frame checks clean.
- Sits between the MIPS UART peripheral register (data/transmit strobe) and the serial tx pin.

Parameters:
- TxNbit, 8, number of data bits per frame.
- BAUD_DIV, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Txbuff  input  TxNbit  data word to send; sampled only on accept.
- transmit  input  1  start request; accepted when high while busy=0.
- parity_en  input  1  1 = include parity bit; sampled only on accept.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse on the last clock of the stop bit.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, tx=1, busy=0, tx_done=0, all counters and shift register cleared. Reset mid-frame aborts the frame immediately; tx returns to 1 without waiting for a clock edge.
- FSM states: IDLE -> START -> DATA -> (PARITY if latched parity_en) -> STOP -> IDLE.
- Accept:
  - Happens in IDLE on the rising edge where transmit=1.
  - Latch Txbuff into the shift register, latch parity_en, latch parity = ~^Txbuff.
  - Go to START, set busy=1 from the next cycle.
- Bit timing:
  - A bit counter counts 0..BAUD_DIV-1; each state holds tx for exactly BAUD_DIV cycles.
  - The counter clears on every state or bit change.
- START: tx=0 for BAUD_DIV cycles.
- DATA:
  - tx = shift register bit 0.
  - After each BAUD_DIV cycles, shift right and increment the bit index.
  - After bit TxNbit-1, go to PARITY or STOP.
- PARITY: tx = latched parity bit for BAUD_DIV cycles.
- STOP:
  - tx=1 for BAUD_DIV cycles; tx_done=1 in the final cycle only.
  - Next cycle: IDLE, busy=0.
- Frame length: (TxNbit+2+parity_en)*BAUD_DIV cycles, measured from the first START cycle.
- Outputs are registered and glitch-free; tx changes only on clk edges, except on asynchronous reset.
- transmit while busy=1 (including the tx_done cycle) is ignored. It is not queued.
- A transmit held high continuously starts a new frame on the first IDLE cycle, giving back-to-back frames with exactly one idle-high cycle between them.
- Changes on Txbuff or parity_en during a frame have no effect on the frame in progress.

Test Plan (BAUD_DIV=4, TxNbit=8):
- Reset release, transmit=0 for 20 cycles -> tx=1, busy=0, tx_done=0 throughout.
- Txbuff=0x55, parity_en=1, transmit pulse -> tx sequence 0,1,0,1,0,1,0,1,0,1,1 (start, LSB-first data, parity=1, stop), each bit 4 cycles. busy high for 44 cycles. tx_done high in cycle 44 only.
- Txbuff=0x07, parity_en=1 -> parity bit 0. Txbuff=0x07, parity_en=0 -> 10-bit frame, 40 cycles, stop bit directly after bit 7.
- Second transmit pulse mid-frame, with Txbuff changed to 0xFF -> first frame bits unchanged, no second frame starts, busy falls once.
- transmit held high, Txbuff=0xA3 -> two identical frames separated by exactly 1 idle cycle with tx=1. tx_done pulses twice.
- reset asserted during DATA bit 3 -> tx=1 and busy=0 immediately, without waiting for a clock edge. After release, a new 0x3C frame transmits correctly.
